alu_cmd_engine: RTL and testbench
=================================

ALU_CMD_ENGINE -- requirements
Module: alu_cmd_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width (8..64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, command queue entries (power of 2, >=2).
REQ-003 SHALL have parameter MUL_CYCLES, default 3, multiply execute latency (>=1).
REQ-004 SHALL have port clk  input  1  the only clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  command valid; accepted on an edge where start && ready.
REQ-007 SHALL have port op  input  4  opcode: 0 nop, 1 add, 2 and, 3 xor, 4 mul, 5 div, other values illegal.
REQ-008 SHALL have port sv  input  1  1 = signed operands, 0 = unsigned.
REQ-009 SHALL have ports A, B  input  DATA_W  operands.
REQ-010 SHALL have port ready  output  1  queue not full.
REQ-011 SHALL have port busy  output  1  queue non-empty or execution in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse; result/err valid while high.
REQ-013 SHALL have port result  output  2*DATA_W  operation result.
REQ-014 SHALL have port err  output  8  bit0 divide-by-zero, bit1 illegal op, bit2 signed overflow, bits7:3 zero.

Function
REQ-015 SHALL enqueue {op,sv,A,B} into an in-order FIFO on each edge with start && ready; start high across N edges enqueues N commands.
REQ-016 SHALL drive ready = 0 when FIFO holds FIFO_DEPTH entries; start ignored then, no overwrite.
REQ-017 SHALL run FSM IDLE -> EXEC -> DONE; IDLE pops head when FIFO non-empty; EXEC counts L(op) cycles; DONE lasts one cycle, then pops next to EXEC if non-empty, else IDLE.
REQ-018 SHALL use L = 1 for nop/add/and/xor/illegal, MUL_CYCLES for mul, DATA_W+1 for div.
REQ-019 SHALL, for a command accepted at edge E0 into an idle engine, assert done for the cycle after edge E0+1+L; back-to-back done spacing is L+1 cycles.
REQ-020 SHALL allow enqueue and pop on the same edge, occupancy unchanged.
REQ-021 SHALL compute add as DATA_W+1-bit sum, sign- (sv=1) or zero-extended (sv=0) to 2*DATA_W; err bit2 if sv=1 and sum overflows DATA_W bits.
REQ-022 SHALL compute and/xor bitwise, zero-extended; nop result 0.
REQ-023 SHALL compute mul as full 2*DATA_W product, signed per sv.
REQ-024 SHALL compute div iteratively: quotient in result[DATA_W-1:0], remainder in result[2*DATA_W-1:DATA_W]; signed truncates toward zero, remainder takes dividend sign.
REQ-025 SHALL, for B=0, return result 0 with err bit0; for sv=1, A=most-negative, B=-1, return quotient = A, remainder 0, err bit2.
REQ-026 SHALL, for illegal op, return result 0 with err bit1.
REQ-027 SHALL hold result/err stable from done until the next done.

Reset
REQ-028 SHALL, on reset, flush FIFO, abort any execution, enter IDLE; ready=1, busy=0, done=0, result=0, err=0 on the following cycle.
REQ-029 SHALL ignore start on an edge where reset is high.

Configuration
REQ-030 SHALL, with macro ALU_CMD_DIV_EN defined, implement div per REQ-024/025.
REQ-031 SHALL, without ALU_CMD_DIV_EN, omit divider logic and treat op 5 as illegal (REQ-026, L=1).

Verification (DATA_W=32, FIFO_DEPTH=4, MUL_CYCLES=3)
REQ-032 SHALL cover: reset, add A=0xFFFFFFFF B=1 sv=0 accepted at E0 -> done after E0+2, result=0x1_0000_0000, err=0.
REQ-033 SHALL cover: mul sv=1 A=-3 B=7 -> result=0xFFFFFFFF_FFFFFFEB after 3 EXEC cycles, err=0.
REQ-034 SHALL cover: div sv=1 A=-7 B=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; div B=0 -> result 0, err=0x01.
REQ-035 SHALL cover: start held 6 cycles while engine busy -> ready drops after 4 queued, only accepted commands complete, in order.
REQ-036 SHALL cover: op=9 -> err=0x02, result 0; add sv=1 0x7FFFFFFF+1 -> err=0x04.
REQ-037 SHALL cover: reset asserted mid-div with 3 queued -> no done afterward, ready=1, busy=0.

Source files
------------

// File: rtl/alu_cmd_engine.sv
// alu_cmd_engine: queued multi-cycle ALU command engine.
// Commands {op, sv, A, B} are accepted on start && ready into an in-order FIFO
// and executed one at a time by an IDLE -> EXEC -> DONE sequencer.
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   start          - command valid (accepted when ready is high)
//   op, sv, A, B   - opcode (0 nop,1 add,2 and,3 xor,4 mul,5 div), signedness, operands
//   ready          - command queue not full
//   busy           - queue non-empty or a command in flight
//   done           - one-cycle pulse, result/err valid
//   result, err    - 2*DATA_W result; err[0] div-by-zero, err[1] illegal op, err[2] overflow
// Build option: define ALU_CMD_DIV_EN to include the iterative divider;
// without it op 5 is reported as an illegal opcode.
module alu_cmd_engine #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            op,
    input  logic                  sv,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   result,
    output logic [7:0]            err
);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W   = PTR_W + 1;
    localparam int unsigned DIV_LAT = DATA_W + 1;
    localparam int unsigned LAT_MAX = (MUL_CYCLES > DIV_LAT) ? MUL_CYCLES : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
`ifdef ALU_CMD_DIV_EN
    localparam logic [3:0] OP_DIV = 4'd5;
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    typedef struct packed {
        logic [3:0]        op;
        logic              sv;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_nxt_c;
    logic             push_c;
    logic             pop_c;
    logic             busy_nxt_c;
    cmd_t             cmd_in_c;
    cmd_t             head_c;
    cmd_t             cur;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat_m1_c;

    logic [DATA_W:0]     sum_c;
    logic [2*DATA_W-1:0] ax_c;
    logic [2*DATA_W-1:0] bx_c;
    logic [2*DATA_W-1:0] res_c;
    logic                dz_c;
    logic                ill_c;
    logic                ovf_c;

`ifdef ALU_CMD_DIV_EN
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvs;
    logic              neg_a;
    logic              neg_b;
    logic [DATA_W:0]   rem_sh_c;
    logic [DATA_W:0]   diff_c;
    logic [DATA_W-1:0] q_fix_c;
    logic [DATA_W-1:0] r_fix_c;
`endif

    // Queue handshake; pops only happen when the sequencer is free to load.
    always_comb begin
        cmd_in_c   = '{op: op, sv: sv, a: A, b: B};
        head_c     = fifo_mem[rd_ptr];
        push_c     = start && ready && !reset;
        pop_c      = (occ != '0) && ((state == S_IDLE) || (state == S_DONE));
        occ_nxt_c  = occ + OCC_W'(push_c) - OCC_W'(pop_c);
        busy_nxt_c = (occ_nxt_c != '0) || pop_c || (state == S_EXEC);
    end

    // Execute latency minus one for the command about to be loaded.
    always_comb begin
        lat_m1_c = '0;
        case (head_c.op)
            OP_MUL:  lat_m1_c = CNT_W'(MUL_CYCLES - 1);
`ifdef ALU_CMD_DIV_EN
            OP_DIV:  lat_m1_c = CNT_W'(DATA_W);
`endif
            default: lat_m1_c = '0;
        endcase
    end

`ifdef ALU_CMD_DIV_EN
    // Restoring divider step on magnitudes, plus final sign fix-up.
    always_comb begin
        rem_sh_c = {rem, quo[DATA_W-1]};
        diff_c   = rem_sh_c - {1'b0, dvs};
        q_fix_c  = (neg_a ^ neg_b) ? -quo : quo;
        r_fix_c  = neg_a ? -rem : rem;
    end
`endif

    // Result and error flags of the command in flight, taken on its last EXEC cycle.
    always_comb begin
        res_c = '0;
        dz_c  = 1'b0;
        ill_c = 1'b0;
        ovf_c = 1'b0;
        sum_c = cur.sv ? ({cur.a[DATA_W-1], cur.a} + {cur.b[DATA_W-1], cur.b})
                       : ({1'b0, cur.a} + {1'b0, cur.b});
        ax_c  = cur.sv ? {{DATA_W{cur.a[DATA_W-1]}}, cur.a} : {{DATA_W{1'b0}}, cur.a};
        bx_c  = cur.sv ? {{DATA_W{cur.b[DATA_W-1]}}, cur.b} : {{DATA_W{1'b0}}, cur.b};
        case (cur.op)
            OP_NOP: res_c = '0;
            OP_ADD: begin
                res_c = cur.sv ? {{(DATA_W-1){sum_c[DATA_W]}}, sum_c}
                               : {{(DATA_W-1){1'b0}}, sum_c};
                ovf_c = cur.sv && (sum_c[DATA_W] != sum_c[DATA_W-1]);
            end
            OP_AND: res_c = {{DATA_W{1'b0}}, cur.a & cur.b};
            OP_XOR: res_c = {{DATA_W{1'b0}}, cur.a ^ cur.b};
            OP_MUL: res_c = ax_c * bx_c;
`ifdef ALU_CMD_DIV_EN
            OP_DIV: begin
                if (cur.b == '0) begin
                    dz_c = 1'b1;
                end else begin
                    res_c = {r_fix_c, q_fix_c};
                    ovf_c = cur.sv && (cur.a == S_MIN) && (cur.b == '1);
                end
            end
`endif
            default: ill_c = 1'b1;
        endcase
    end

    // Queue storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= cmd_in_c;
        end
    end

    // Queue pointers, sequencer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            err    <= '0;
            state  <= S_IDLE;
            cnt    <= '0;
            cur    <= '0;
`ifdef ALU_CMD_DIV_EN
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            occ   <= occ_nxt_c;
            ready <= (occ_nxt_c != OCC_W'(FIFO_DEPTH));
            busy  <= busy_nxt_c;
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case (state)
                S_EXEC: begin
                    if (cnt == '0) begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        result <= res_c;
                        err    <= {5'b0, ovf_c, ill_c, dz_c};
                    end else begin
                        cnt <= cnt - CNT_W'(1);
`ifdef ALU_CMD_DIV_EN
                        if (cur.op == OP_DIV) begin
                            if (!diff_c[DATA_W]) begin
                                rem <= diff_c[DATA_W-1:0];
                                quo <= {quo[DATA_W-2:0], 1'b1};
                            end else begin
                                rem <= rem_sh_c[DATA_W-1:0];
                                quo <= {quo[DATA_W-2:0], 1'b0};
                            end
                        end
`endif
                    end
                end
                default: begin
                    // IDLE and DONE both load the next queued command if present.
                    if (pop_c) begin
                        state <= S_EXEC;
                        cur   <= head_c;
                        cnt   <= lat_m1_c;
`ifdef ALU_CMD_DIV_EN
                        neg_a <= head_c.sv && head_c.a[DATA_W-1];
                        neg_b <= head_c.sv && head_c.b[DATA_W-1];
                        quo   <= (head_c.sv && head_c.a[DATA_W-1]) ? -head_c.a : head_c.a;
                        dvs   <= (head_c.sv && head_c.b[DATA_W-1]) ? -head_c.b : head_c.b;
                        rem   <= '0;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_engine.sv
// Directed self-checking bench for alu_cmd_engine (DATA_W=32, FIFO_DEPTH=4, MUL_CYCLES=3).
// Expected values follow the ALU_CMD_DIV_EN build option of the compile.
module tb_alu_cmd_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic        sv = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [7:0]  err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned c_acc    = 0;

    logic [63:0] done_res [$];
    logic [7:0]  done_err [$];
    int unsigned done_cyc [$];

    alu_cmd_engine #(
        .DATA_W     (32),
        .FIFO_DEPTH (4),
        .MUL_CYCLES (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .sv     (sv),
        .A      (A),
        .B      (B),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every done pulse mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_res.push_back(result);
            done_err.push_back(err);
            done_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        done_res.delete();
        done_err.delete();
        done_cyc.delete();
    endtask

    task automatic wait_dones(input int unsigned n, input int unsigned budget);
        int unsigned i = 0;
        while (done_res.size() < n && i < budget) begin
            tick();
            i++;
        end
    endtask

    task automatic run_one(input string tag, input logic [3:0] o, input logic s,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_res, input logic [7:0] exp_err,
                           input int unsigned exp_lat);
        clear_log();
        op = o; sv = s; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        c_acc = cyc;
        wait_dones(1, 80);
        check_eq({tag, "_ndone"}, 64'(done_res.size()), 64'd1);
        if (done_res.size() > 0) begin
            check_eq({tag, "_res"}, done_res[0], exp_res);
            check_eq({tag, "_err"}, 64'(done_err[0]), 64'(exp_err));
            check_eq({tag, "_lat"}, 64'(done_cyc[0] - c_acc), 64'(exp_lat));
        end
        tick();
        check_eq({tag, "_done_low"}, 64'(done), 64'd0);
        check_eq({tag, "_hold"}, result, exp_res);
    endtask

    localparam logic [63:0] MUL_RES [6] = '{64'd200, 64'd3, 64'd6, 64'd9, 64'd12, 64'd15};
    localparam logic        RDY_EXP [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        // Reset with start held high: nothing may be queued.
        reset = 1'b1; start = 1'b1; op = 4'd1;
        tick();
        tick();
        reset = 1'b0; start = 1'b0;
        check_eq("rst_ready", 64'(ready), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        clear_log();
        repeat (5) tick();
        check_eq("rst_no_cmd", 64'(done_res.size()), 64'd0);
        check_eq("rst_idle_busy", 64'(busy), 64'd0);

        run_one("add_u_carry", 4'd1, 1'b0, 32'hFFFF_FFFF, 32'h1, 64'h0000_0001_0000_0000, 8'h00, 2);
        run_one("add_s_ovf",   4'd1, 1'b1, 32'h7FFF_FFFF, 32'h1, 64'h0000_0000_8000_0000, 8'h04, 2);
        run_one("add_s_neg",   4'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 8'h00, 2);
        run_one("and",         4'd2, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_F000_F000, 8'h00, 2);
        run_one("xor",         4'd3, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_0FF0_0FF0, 8'h00, 2);
        run_one("nop",         4'd0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0, 8'h00, 2);
        run_one("mul_s",       4'd4, 1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 8'h00, 4);
        run_one("mul_u",       4'd4, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 8'h00, 4);
        run_one("illegal",     4'd9, 1'b0, 32'd5, 32'd6, 64'h0, 8'h02, 2);
`ifdef ALU_CMD_DIV_EN
        run_one("div_s",       4'd5, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8'h00, 34);
        run_one("div_s_nb",    4'd5, 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 8'h00, 34);
        run_one("div_u",       4'd5, 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 8'h00, 34);
        run_one("div_zero",    4'd5, 1'b0, 32'd7, 32'd0, 64'h0, 8'h01, 34);
        run_one("div_min_m1",  4'd5, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 8'h04, 34);
`else
        run_one("div_off",     4'd5, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'h0, 8'h02, 2);
        run_one("div_off_b0",  4'd5, 1'b0, 32'd7, 32'd0, 64'h0, 8'h02, 2);
`endif

        // Queue fill: one mul in flight, then start held for 6 edges with muls A=k, B=3.
        clear_log();
        op = 4'd4; sv = 1'b0; A = 32'd100; B = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("q_busy", 64'(busy), 64'd1);
        for (int k = 1; k <= 6; k++) begin
            A = 32'(k); B = 32'd3; start = 1'b1;
            tick();
            check_eq($sformatf("q_ready_%0d", k), 64'(ready), 64'(RDY_EXP[k-1]));
        end
        start = 1'b0;
        wait_dones(6, 100);
        check_eq("q_ndone", 64'(done_res.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < done_res.size()) begin
                check_eq($sformatf("q_res_%0d", i), done_res[i], MUL_RES[i]);
                if (i > 0) begin
                    check_eq($sformatf("q_gap_%0d", i), 64'(done_cyc[i] - done_cyc[i-1]), 64'd4);
                end
            end
        end
        repeat (20) tick();
        check_eq("q_no_extra", 64'(done_res.size()), 64'd6);
        check_eq("q_idle_busy", 64'(busy), 64'd0);
        check_eq("q_idle_ready", 64'(ready), 64'd1);

        // Reset while a long command runs with three more queued.
        clear_log();
`ifdef ALU_CMD_DIV_EN
        op = 4'd5;
`else
        op = 4'd4;
`endif
        sv = 1'b1; A = 32'hFFFF_FFF9; B = 32'd2; start = 1'b1;
        tick();
        repeat (3) tick();
        check_eq("mr_busy_pre", 64'(busy), 64'd1);
        check_eq("mr_no_done_pre", 64'(done_res.size()), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        check_eq("mr_ready", 64'(ready), 64'd1);
        check_eq("mr_busy", 64'(busy), 64'd0);
        check_eq("mr_done", 64'(done), 64'd0);
        check_eq("mr_result", result, 64'd0);
        check_eq("mr_err", 64'(err), 64'd0);
        repeat (60) tick();
        check_eq("mr_no_done_post", 64'(done_res.size()), 64'd0);
        check_eq("mr_busy_post", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
